// File: rtl/pipe_pkg.sv
// Shared fetch-side types and constants for the dual-issue pipeline.
package pipe_pkg;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      STALL = 2'd1,
      FLUSH = 2'd2
   } fetch_state_t;

   localparam logic [15:0] NOP_INST = 16'h0000;
   localparam int          PC_STEP  = 4;

endpackage

// File: rtl/stall_watchdog.sv
// Consecutive-stall counter with a sticky overrun flag that only reset clears.
module stall_watchdog #(
   parameter int MAX_STALL = 8
) (
   input  logic clk,
   input  logic rst_n,
   input  logic stall,
   input  logic in_stall,
   output logic stall_err
);

   localparam int CW = $clog2(MAX_STALL + 1);
   localparam logic [CW-1:0] MAX_CNT = CW'(MAX_STALL);

   logic [CW-1:0] cnt_reg;
   logic [CW-1:0] cnt_next;
   logic          stall_err_reg;

   // A stall that does not continue an existing STALL run starts a fresh count.
   always_comb begin
      cnt_next = '0;
      if (stall) begin
         if (!in_stall)
            cnt_next = CW'(1);
         else if (cnt_reg != MAX_CNT)
            cnt_next = cnt_reg + CW'(1);
         else
            cnt_next = cnt_reg;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_reg       <= '0;
         stall_err_reg <= 1'b0;
      end else begin
         cnt_reg <= cnt_next;
         if (stall && cnt_next == MAX_CNT)
            stall_err_reg <= 1'b1;
      end
   end

   assign stall_err = stall_err_reg;

endmodule

// File: rtl/fetch_stall_ctrl.sv
// PC register and two-slot IF/ID register driven by hazard-unit stall requests.
// Optional perf counters are enabled with `define FETCH_STALL_PERF_EN.
module fetch_stall_ctrl
   import pipe_pkg::*;
#(
   parameter int PC_W      = 16,
   parameter int INST_W    = 16,
   parameter int RESET_PC  = 0,
   parameter int MAX_STALL = 8,
   parameter int CNT_W     = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              pc_write,
   input  logic              if_id_write,
   input  logic              cntrl_sel,
   input  logic              branch_taken,
   input  logic [PC_W-1:0]   branch_target,
   input  logic              imem_valid,
   input  logic [INST_W-1:0] imem_inst1,
   input  logic [INST_W-1:0] imem_inst2,
   output logic [PC_W-1:0]   pc,
   output logic [INST_W-1:0] if_id_inst1,
   output logic [INST_W-1:0] if_id_inst2,
   output logic [PC_W-1:0]   if_id_pc,
   output logic              if_id_valid,
   output logic              protocol_err,
   output logic              stall_err,
   output logic [CNT_W-1:0]  stall_cycles,
   output logic [CNT_W-1:0]  flush_count
);

   localparam logic [INST_W-1:0] NOP = INST_W'(NOP_INST);

   fetch_state_t      state_reg;
   logic [PC_W-1:0]   pc_reg;
   logic [INST_W-1:0] inst1_reg;
   logic [INST_W-1:0] inst2_reg;
   logic [PC_W-1:0]   if_id_pc_reg;
   logic              valid_reg;
   logic              protocol_err_reg;

   logic req_bad;
   logic write_ok;
   logic redirect;
   logic stall;

   // Mismatched write enables collapse to a stall, which also blocks any redirect.
   always_comb begin
      req_bad  = (cntrl_sel == if_id_write) | (pc_write ^ if_id_write)
               | (branch_taken & ~pc_write);
      write_ok = pc_write & if_id_write;
      redirect = branch_taken & write_ok;
      stall    = ~write_ok;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg        <= RUN;
         pc_reg           <= PC_W'(RESET_PC);
         inst1_reg        <= NOP;
         inst2_reg        <= NOP;
         if_id_pc_reg     <= '0;
         valid_reg        <= 1'b0;
         protocol_err_reg <= 1'b0;
      end else begin
         if (req_bad)
            protocol_err_reg <= 1'b1;
         if (redirect) begin
            pc_reg    <= branch_target;
            inst1_reg <= NOP;
            inst2_reg <= NOP;
            valid_reg <= 1'b0;
            state_reg <= FLUSH;
         end else if (stall) begin
            state_reg <= STALL;
         end else if (!imem_valid) begin
            inst1_reg <= NOP;
            inst2_reg <= NOP;
            valid_reg <= 1'b0;
            state_reg <= RUN;
         end else begin
            pc_reg       <= pc_reg + PC_W'(PC_STEP);
            inst1_reg    <= imem_inst1;
            inst2_reg    <= imem_inst2;
            if_id_pc_reg <= pc_reg;
            valid_reg    <= 1'b1;
            state_reg    <= RUN;
         end
      end
   end

   stall_watchdog #(
      .MAX_STALL (MAX_STALL)
   ) u_watchdog (
      .clk       (clk),
      .rst_n     (rst_n),
      .stall     (stall),
      .in_stall  (state_reg == STALL),
      .stall_err (stall_err)
   );

`ifdef FETCH_STALL_PERF_EN
   logic [CNT_W-1:0] stall_cycles_reg;
   logic [CNT_W-1:0] flush_count_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cycles_reg <= '0;
         flush_count_reg  <= '0;
      end else begin
         if (stall && stall_cycles_reg != '1)
            stall_cycles_reg <= stall_cycles_reg + CNT_W'(1);
         if (redirect && flush_count_reg != '1)
            flush_count_reg <= flush_count_reg + CNT_W'(1);
      end
   end

   assign stall_cycles = stall_cycles_reg;
   assign flush_count  = flush_count_reg;
`else
   assign stall_cycles = '0;
   assign flush_count  = '0;
`endif

   assign pc           = pc_reg;
   assign if_id_inst1  = inst1_reg;
   assign if_id_inst2  = inst2_reg;
   assign if_id_pc     = if_id_pc_reg;
   assign if_id_valid  = valid_reg;
   assign protocol_err = protocol_err_reg;

endmodule
